// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// The transmitter and receiver both import this package.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int UART_DBIT    = 8;
    localparam int UART_SB_TICK = 16;

    // Counter width for a count range of n values; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises DBIT data bits LSB first between a start bit and
// a stop bit of SB_TICK sample ticks, pacing every bit on the external 16x tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_din,
    output logic            o_tx,
    output logic            o_busy,
    output logic            o_tx_done_tick
);

    // The tick counter widens beyond 4 bits only when the stop bit is longer than 16 ticks.
    localparam int SW = cnt_width((SB_TICK > 16) ? SB_TICK : 16);
    localparam int NW = cnt_width(DBIT);

    localparam logic [SW-1:0] S_LAST_BIT  = SW'(15);
    localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick arriving together with the start request is deliberately not counted.
                if (i_tx_start) begin
                    b_d     = i_din;
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (i_s_tick) begin
                    if (s_cnt_q == S_LAST_BIT) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (i_s_tick) begin
                    if (s_cnt_q == S_LAST_BIT) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (i_s_tick) begin
                    if (s_cnt_q == S_LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_busy         = (state_q != IDLE);
    assign o_tx_done_tick = done_q;

endmodule
